// File: rtl/data_mem_sync_if.sv
// Request/response bundle between the execute stage and the data memory.
// The master drives the request side; the memory drives the response side.
interface data_mem_sync_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  req;
    logic                  rw;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W/8-1:0]   be;
    logic [DATA_W-1:0]     wd;
    logic                  ready;
    logic                  rvalid;
    logic [DATA_W-1:0]     rd;
    logic                  err;

    modport master (
        output req, rw, addr, be, wd,
        input  ready, rvalid, rd, err
    );

    modport slave (
        input  req, rw, addr, be, wd,
        output ready, rvalid, rd, err
    );
endinterface

// File: rtl/data_mem_sync.sv
// Single-port data memory: byte-enable writes, 1-cycle registered reads,
// range/alignment error flagging and optional zero-fill sweep after reset.
module data_mem_sync #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 1024,
    parameter int ADDR_W    = 32,
    parameter int INIT_ZERO = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    data_mem_sync_if.slave   bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);

    // One extra bit so the limit is representable even when it equals 2**ADDR_W.
    localparam logic [ADDR_W:0]   LIMIT      = (ADDR_W+1)'(DEPTH * BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(DEPTH - 1);

    typedef enum logic {S_INIT, S_IDLE} state_e;
    localparam state_e RST_STATE = (INIT_ZERO != 0) ? S_INIT : S_IDLE;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     cnt_q, cnt_d;
    logic                 ready_q, ready_d;
    logic                 rvalid_q, rvalid_d;
    logic                 err_q, err_d;
    logic [DATA_W-1:0]    rd_q, rd_d;

    logic [DATA_W-1:0]    mem [DEPTH];

    logic                 accept;
    logic                 bad;
    logic                 wr_en;
    logic                 init_wr;
    logic [IDX_W-1:0]     idx;

    assign accept  = bus.req & ready_q;
    assign bad     = ({1'b0, bus.addr} >= LIMIT) | (|(bus.addr & ALIGN_MASK));
    assign idx     = bus.addr[OFF +: IDX_W];
    assign wr_en   = accept & bus.rw & ~bad;
    // Held off while reset is asserted so reset itself never disturbs the array.
    assign init_wr = (state_q == S_INIT) & rst_n;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        rd_d     = rd_q;

        if (state_q == S_INIT) begin
            cnt_d = cnt_q + IDX_W'(1);
            if (cnt_q == LAST_IDX) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        end

        if (accept) begin
            err_d = bad;
            if (!bus.rw) begin
                rvalid_d = 1'b1;
                rd_d     = bad ? '0 : mem[idx];
            end
        end

        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RST_STATE;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rd_q     <= rd_d;
        end
    end

    // Storage: INIT sweep and accepted writes never overlap since READY is low in INIT.
    always_ff @(posedge clk) begin
        if (init_wr) begin
            mem[cnt_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < BYTES; i++) begin
                if (bus.be[i]) mem[idx][8*i +: 8] <= bus.wd[8*i +: 8];
            end
        end
    end

    assign bus.ready  = ready_q;
    assign bus.rvalid = rvalid_q;
    assign bus.rd     = rd_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_data_mem_sync.sv
// Bench for data_mem_sync (32-bit words, 16 entries): directed scenarios
// plus randomized traffic against a word-array reference model.
module tb_data_mem_sync;
    logic clk = 1'b0;
    logic rst_n;
    bit   chk_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    data_mem_sync_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    data_mem_sync #(.DATA_W(32), .DEPTH(16), .ADDR_W(32), .INIT_ZERO(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: cycles since reset release, word array, expected outputs.
    int          m_cnt = 0;
    logic [31:0] m_mem [16];
    logic        m_rvalid = 1'b0;
    logic        m_err = 1'b0;
    logic [31:0] m_rd = '0;

    function automatic bit is_bad(input logic [31:0] a);
        return (a >= 32'd64) || (a[1:0] != 2'b00);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt    <= 0;
            m_rvalid <= 1'b0;
            m_err    <= 1'b0;
            m_rd     <= '0;
            for (int i = 0; i < 16; i++) m_mem[i] <= '0;
        end else begin
            m_rvalid <= 1'b0;
            m_err    <= 1'b0;
            if (m_cnt < 16) begin
                m_cnt <= m_cnt + 1;
            end else if (bus.req) begin
                if (is_bad(bus.addr)) begin
                    m_err <= 1'b1;
                    if (!bus.rw) begin
                        m_rvalid <= 1'b1;
                        m_rd     <= '0;
                    end
                end else if (!bus.rw) begin
                    m_rvalid <= 1'b1;
                    m_rd     <= m_mem[bus.addr[5:2]];
                end else begin
                    for (int i = 0; i < 4; i++)
                        if (bus.be[i]) m_mem[bus.addr[5:2]][8*i +: 8] <= bus.wd[8*i +: 8];
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready",  bus.ready,  m_cnt >= 16);
            check("rvalid", bus.rvalid, m_rvalid);
            check("err",    bus.err,    m_err);
            check("rd",     bus.rd,     m_rd);
        end
    end

    task automatic op(input bit w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        bus.req  = 1'b1;
        bus.rw   = w;
        bus.addr = a;
        bus.be   = b;
        bus.wd   = d;
        @(negedge clk);
    endtask

    task automatic idle();
        bus.req = 1'b0;
        @(negedge clk);
    endtask

    // Counts READY-low cycles from release; optionally pokes a write at cycle 3.
    task automatic wait_init(input bit poke);
        int n = 0;
        while (!bus.ready && n < 100) begin
            if (poke && n == 3) begin
                bus.req  = 1'b1;
                bus.rw   = 1'b1;
                bus.addr = 32'h0;
                bus.be   = 4'hF;
                bus.wd   = 32'hFF;
            end else begin
                bus.req = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        bus.req = 1'b0;
        check("init_len", n, 16);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        rst_n    = 1'b0;
        bus.req  = 1'b0;
        bus.rw   = 1'b0;
        bus.addr = '0;
        bus.be   = '0;
        bus.wd   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_ready", bus.ready, 0);
        check("rst_rd", bus.rd, 0);
        rst_n = 1'b1;
        wait_init(1'b1);

        for (int i = 0; i < 64; i += 4) begin
            op(1'b0, 32'(i), 4'h0, 32'h0);
            check("zero_rd", bus.rd, 32'h0);
        end
        check("zero_rvalid", bus.rvalid, 1);

        op(1'b1, 32'h08, 4'hF, 32'hDEADBEEF);
        check("wr_no_rvalid", bus.rvalid, 0);
        op(1'b0, 32'h08, 4'h0, 32'h0);
        check("rd_full", bus.rd, 32'hDEADBEEF);
        check("rd_full_vld", bus.rvalid, 1);
        idle();
        check("rvalid_pulse", bus.rvalid, 0);
        check("rd_hold", bus.rd, 32'hDEADBEEF);

        op(1'b1, 32'h08, 4'b0101, 32'h11223344);
        op(1'b0, 32'h08, 4'h0, 32'h0);
        check("rd_be", bus.rd, 32'hDE22BE44);

        op(1'b1, 32'h40, 4'hF, 32'hCAFEF00D);
        check("err_oor_wr", bus.err, 1);
        check("err_oor_novld", bus.rvalid, 0);
        op(1'b0, 32'h09, 4'h0, 32'h0);
        check("err_mis", bus.err, 1);
        check("err_mis_vld", bus.rvalid, 1);
        check("err_mis_rd", bus.rd, 32'h0);
        op(1'b0, 32'h00, 4'h0, 32'h0);
        check("no_alias_rd0", bus.rd, 32'h0);
        check("no_alias_err", bus.err, 0);

        op(1'b1, 32'h08, 4'h0, 32'hFFFFFFFF);
        check("be0_noerr", bus.err, 0);
        op(1'b0, 32'h08, 4'h0, 32'h0);
        check("be0_rd", bus.rd, 32'hDE22BE44);
        idle();

        // Reset lands while an accepted read's RVALID is in flight.
        bus.req  = 1'b1;
        bus.rw   = 1'b0;
        bus.addr = 32'h08;
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        bus.req = 1'b0;
        #1;
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_ready2", bus.ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init(1'b0);
        op(1'b0, 32'h08, 4'h0, 32'h0);
        check("post_rst_rd", bus.rd, 32'h0);

        repeat (800) begin
            r = $urandom;
            a = 32'($urandom_range(0, 32'h4F));
            if (r[5:4] != 2'b00) a[1:0] = 2'b00;
            if (r[9:6] == 4'h0) a = 32'h8000_0000 | {26'h0, a[5:0]};
            bus.req  = (r[3:0] < 4'd11);
            bus.rw   = r[10];
            bus.addr = a;
            bus.be   = r[14:11];
            bus.wd   = $urandom;
            @(negedge clk);
        end
        idle();
        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
